comp_ctrl: RTL and testbench
============================

Name: comp_ctrl

Overview:
Initiator and sequencer for the computational block. Accepts a frame of N RGB pixels over a valid/ready stream and launches one computation per pixel with a single-cycle start_comp pulse. It waits for comp_done, captures the result, and presents it on an output valid/ready stream. Sits between the pixel input buffer and the output writer; provides a watchdog timeout and pass-through for mode 2'b00.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in WAIT before declaring timeout (1..65535)
CNT_W, 16, width of the frame pixel counter

Ports:
clk  in  1  system clock, all logic on rising edge
n_rst  in  1  synchronous active-low reset, sampled on rising edge of clk
frame_start  in  1  one-cycle pulse; latches num_pixels and mode_in, begins frame (ignored unless IDLE)
num_pixels  in  CNT_W  pixels in frame; 0 = empty frame
mode_in  in  2  computation mode for whole frame (00 bypass, 01 invert, 10 grey, 11 correct)
pix_valid  in  1  input pixel available
pix_r / pix_g / pix_b  in  8 each  input pixel
pix_ready  out  1  controller accepts pixel this cycle
comp_r / comp_g / comp_b  out  8 each  operands to computational block
comp_mode  out  2  mode to computational block
start_comp  out  1  launch pulse, exactly one cycle high
comp_done  in  1  completion from computational block (level; rising edge used)
res_r / res_g / res_b  in  8 each  results from computational block
out_valid  out  1  result pixel valid
out_r / out_g / out_b  out  8 each  result pixel
out_ready  in  1  downstream accepts
busy  out  1  high in any state but IDLE
frame_done  out  1  one-cycle pulse when last pixel handed off or empty frame ends
timeout_err  out  1  sticky; set on any watchdog expiry, cleared by frame_start or reset

Behaviour:
- Reset (n_rst=0 at clock edge): state IDLE; every output 0; counters 0; done_q 0. Reset mid-frame aborts immediately, with no frame_done.
- States: IDLE, FETCH, LAUNCH, WAIT, EMIT, DONE.
- IDLE: on frame_start, latch num_pixels into remaining, latch mode_in into comp_mode, clear timeout_err. Go to DONE if num_pixels==0, else FETCH.
- FETCH: pix_ready=1 (combinational on state). On pix_valid, register the pixel into comp_r/g/b. Go to LAUNCH, or to EMIT if mode==00, with out_* = input pixel.
- LAUNCH: start_comp=1 for this one cycle; clear wait counter; go to WAIT.
- WAIT: start_comp=0. done_q <= comp_done every cycle; done_edge = comp_done & ~done_q.
  - On done_edge: capture res_* into out_* and go to EMIT.
  - Otherwise increment wait counter. At TIMEOUT_CYCLES-1 without done_edge, set timeout_err, load out_* with the unmodified input pixel, and go to EMIT.
  - A done_edge in the expiry cycle takes priority (result used, no error).
  - done_q also updates in every other state, so a comp_done stuck high never produces an edge and always times out.
- EMIT: out_valid=1 with out_* held stable until out_ready.
  - On handshake: remaining decrements. If it reaches 0, go to DONE, else FETCH.
  - out_valid may not drop before the handshake.
- DONE: frame_done=1 for one cycle, then IDLE.
- frame_start outside IDLE is ignored; no queuing.
- Latency per pixel, with ready/valid always high and done one cycle after launch: FETCH→LAUNCH→WAIT→EMIT = 4 cycles. Bypass: 2 cycles.
- The counter never wraps: decrement only when remaining>0.
- comp_r/g/b and comp_mode are held stable from LAUNCH through WAIT.

Optional Feature:
COMP_CTRL_STATS_EN
- Defined: adds output ports pix_count [CNT_W-1:0] and to_count [15:0].
  - pix_count counts pixels emitted in the current frame.
  - to_count counts timeouts since reset, saturating at 16'hFFFF.
  - Both reset to 0; pix_count also clears on an accepted frame_start.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Bypass: num_pixels=3, mode 00, pixels (10,20,30),(40,50,60),(70,80,90) -> out_* identical in order, start_comp never pulses, frame_done one cycle after the third handshake.
- Invert: mode 01, pixel (0x12,0x34,0x56), model drives res=(0xED,0xCB,0xA9) with comp_done rising 3 cycles after start_comp -> out=(0xED,0xCB,0xA9), start_comp high exactly 1 cycle, timeout_err=0.
- Timeout: TIMEOUT_CYCLES=8, comp_done held 0, pixel (1,2,3) -> EMIT after 8 WAIT cycles, out=(1,2,3), timeout_err=1 (to_count=1 with stats). Next frame_start clears timeout_err.
- Stuck done: comp_done held 1 from reset, num_pixels=2 -> both pixels time out; two output handshakes; frame_done pulses.
- Backpressure/empty: out_ready low 5 cycles in EMIT -> out_* stable, pix_ready=0 throughout. num_pixels=0 -> frame_done on the cycle after frame_start, busy high for 1 cycle.
- Reset mid-WAIT: n_rst=0 for one edge -> all outputs 0, state IDLE, no frame_done; a new frame afterwards completes normally.

Source files
------------

// File: rtl/comp_ctrl_if.sv
// comp_ctrl_if: bundles the frame control, pixel input stream, compute-block
// handshake, result output stream and status signals of comp_ctrl.
//   master : the controller side (comp_ctrl)
//   slave  : the surrounding environment (input buffer, compute block, writer)
// Parameter CNT_W sets the width of num_pixels.
interface comp_ctrl_if #(
    parameter int CNT_W = 16
);
    // frame control
    logic             frame_start;
    logic [CNT_W-1:0] num_pixels;
    logic [1:0]       mode_in;
    // pixel input stream
    logic             pix_valid;
    logic             pix_ready;
    logic [7:0]       pix_r;
    logic [7:0]       pix_g;
    logic [7:0]       pix_b;
    // computational block
    logic [7:0]       comp_r;
    logic [7:0]       comp_g;
    logic [7:0]       comp_b;
    logic [1:0]       comp_mode;
    logic             start_comp;
    logic             comp_done;
    logic [7:0]       res_r;
    logic [7:0]       res_g;
    logic [7:0]       res_b;
    // result output stream
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_r;
    logic [7:0]       out_g;
    logic [7:0]       out_b;
    // status
    logic             busy;
    logic             frame_done;
    logic             timeout_err;

    modport master (
        input  frame_start, num_pixels, mode_in,
        input  pix_valid, pix_r, pix_g, pix_b,
        output pix_ready,
        output comp_r, comp_g, comp_b, comp_mode, start_comp,
        input  comp_done, res_r, res_g, res_b,
        output out_valid, out_r, out_g, out_b,
        input  out_ready,
        output busy, frame_done, timeout_err
    );

    modport slave (
        output frame_start, num_pixels, mode_in,
        output pix_valid, pix_r, pix_g, pix_b,
        input  pix_ready,
        input  comp_r, comp_g, comp_b, comp_mode, start_comp,
        output comp_done, res_r, res_g, res_b,
        input  out_valid, out_r, out_g, out_b,
        output out_ready,
        input  busy, frame_done, timeout_err
    );
endinterface

// File: rtl/comp_ctrl.sv
// comp_ctrl: frame sequencer for the computational block. Accepts a frame of
// RGB pixels on a valid/ready stream, launches one computation per pixel with
// a one-cycle start_comp pulse, waits for the rising edge of comp_done (with a
// watchdog), and presents the result on a valid/ready output stream. Mode 00
// bypasses the compute block and forwards the pixel directly.
//
// Ports:
//   clk    - system clock, rising edge
//   n_rst  - synchronous active-low reset
//   bus    - comp_ctrl_if.master (frame control, pixel in, compute handshake,
//            result out, busy/frame_done/timeout_err status)
// Optional (macro COMP_CTRL_STATS_EN):
//   pix_count - pixels emitted in the current frame
//   to_count  - watchdog expiries since reset, saturating at 16'hFFFF
//
// State table:
//   S_IDLE   | waiting for frame_start
//   S_FETCH  | pix_ready high, waiting for an input pixel
//   S_LAUNCH | start_comp high for one cycle, watchdog loaded
//   S_WAIT   | waiting for comp_done rising edge or watchdog expiry
//   S_EMIT   | out_valid high, result held until out_ready
//   S_DONE   | frame_done high for one cycle
module comp_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic            clk,
    input  logic            n_rst,
    comp_ctrl_if.master     bus
`ifdef COMP_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0] pix_count,
    output logic [15:0]      to_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAUNCH,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    // Watchdog runs as a down-counter: loaded with TIMEOUT_CYCLES-1 in LAUNCH,
    // so WAIT lasts at most TIMEOUT_CYCLES cycles before expiry at zero.
    localparam logic [15:0] WAIT_LOAD = 16'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [15:0]      wait_cnt;
    logic             done_q;
    logic             done_edge;
    logic             timeout_fire;
    logic             emit_hs;

    assign done_edge    = bus.comp_done & ~done_q;
    assign timeout_fire = (state == S_WAIT) && !done_edge && (wait_cnt == 16'd0);
    assign emit_hs      = (state == S_EMIT) && bus.out_ready;

    assign bus.pix_ready  = (state == S_FETCH);
    assign bus.start_comp = (state == S_LAUNCH);
    assign bus.out_valid  = (state == S_EMIT);
    assign bus.frame_done = (state == S_DONE);
    assign bus.busy       = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state           <= S_IDLE;
            remaining       <= '0;
            wait_cnt        <= '0;
            done_q          <= 1'b0;
            bus.comp_r      <= '0;
            bus.comp_g      <= '0;
            bus.comp_b      <= '0;
            bus.comp_mode   <= '0;
            bus.out_r       <= '0;
            bus.out_g       <= '0;
            bus.out_b       <= '0;
            bus.timeout_err <= 1'b0;
        end else begin
            // Tracked in every state so a level stuck high never looks like an edge.
            done_q <= bus.comp_done;

            case (state)
                S_IDLE: begin
                    if (bus.frame_start) begin
                        remaining       <= bus.num_pixels;
                        bus.comp_mode   <= bus.mode_in;
                        bus.timeout_err <= 1'b0;
                        state           <= (bus.num_pixels == '0) ? S_DONE : S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (bus.pix_valid) begin
                        bus.comp_r <= bus.pix_r;
                        bus.comp_g <= bus.pix_g;
                        bus.comp_b <= bus.pix_b;
                        if (bus.comp_mode == 2'b00) begin
                            bus.out_r <= bus.pix_r;
                            bus.out_g <= bus.pix_g;
                            bus.out_b <= bus.pix_b;
                            state     <= S_EMIT;
                        end else begin
                            state     <= S_LAUNCH;
                        end
                    end
                end

                S_LAUNCH: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (done_edge) begin
                        bus.out_r <= bus.res_r;
                        bus.out_g <= bus.res_g;
                        bus.out_b <= bus.res_b;
                        state     <= S_EMIT;
                    end else if (timeout_fire) begin
                        // Fall back to the untouched input pixel still held on comp_*.
                        bus.timeout_err <= 1'b1;
                        bus.out_r       <= bus.comp_r;
                        bus.out_g       <= bus.comp_g;
                        bus.out_b       <= bus.comp_b;
                        state           <= S_EMIT;
                    end else begin
                        wait_cnt <= wait_cnt - 16'd1;
                    end
                end

                S_EMIT: begin
                    if (bus.out_ready) begin
                        if (remaining != '0) begin
                            remaining <= remaining - CNT_W'(1);
                        end
                        state <= (remaining <= CNT_W'(1)) ? S_DONE : S_FETCH;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef COMP_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pix_count <= '0;
            to_count  <= '0;
        end else begin
            if ((state == S_IDLE) && bus.frame_start) begin
                pix_count <= '0;
            end else if (emit_hs) begin
                pix_count <= pix_count + CNT_W'(1);
            end
            if (timeout_fire && (to_count != 16'hFFFF)) begin
                to_count <= to_count + 16'd1;
            end
        end
    end
`else
    // Handshake decode only feeds the statistics counters.
    logic unused_emit_hs;
    assign unused_emit_hs = emit_hs;
`endif

endmodule

// File: tb/tb_comp_ctrl.sv
// tb_comp_ctrl: directed self-checking bench for comp_ctrl (TIMEOUT_CYCLES=8).
// Covers reset, bypass frame, invert with backpressure, watchdog timeout,
// stuck-high comp_done, empty frame and reset in the middle of WAIT.
module tb_comp_ctrl;

    logic clk;
    logic n_rst;
    int   checks;
    int   errors;
    int   sc_cnt;
    int   fd_cnt;

    comp_ctrl_if #(.CNT_W(16)) bus ();

`ifdef COMP_CTRL_STATS_EN
    logic [15:0] pix_count;
    logic [15:0] to_count;
`endif

    comp_ctrl #(
        .TIMEOUT_CYCLES(8),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus)
`ifdef COMP_CTRL_STATS_EN
        ,
        .pix_count(pix_count),
        .to_count(to_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.start_comp === 1'b1) sc_cnt++;
        if (bus.frame_done === 1'b1) fd_cnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        bus.pix_r = r;
        bus.pix_g = g;
        bus.pix_b = b;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        chk({tag, "_r"}, 32'(bus.out_r), 32'(r));
        chk({tag, "_g"}, 32'(bus.out_g), 32'(g));
        chk({tag, "_b"}, 32'(bus.out_b), 32'(b));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sc_cnt = 0;
        fd_cnt = 0;
        n_rst  = 1'b0;
        bus.frame_start = 1'b0;
        bus.num_pixels  = '0;
        bus.mode_in     = 2'b00;
        bus.pix_valid   = 1'b0;
        set_pix(8'h00, 8'h00, 8'h00);
        bus.comp_done   = 1'b0;
        bus.res_r       = 8'h00;
        bus.res_g       = 8'h00;
        bus.res_b       = 8'h00;
        bus.out_ready   = 1'b0;

        // ---- reset ----
        step();
        step();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_start_comp", 32'(bus.start_comp), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        chk("rst_comp_mode", 32'(bus.comp_mode), 32'd0);
        chk_out("rst_out", 8'h00, 8'h00, 8'h00);
        n_rst = 1'b1;
        step();

        // ---- bypass, 3 pixels ----
        sc_cnt = 0;
        fd_cnt = 0;
        bus.num_pixels  = 16'd3;
        bus.mode_in     = 2'b00;
        bus.out_ready   = 1'b1;
        bus.pix_valid   = 1'b1;
        set_pix(8'd10, 8'd20, 8'd30);
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        chk("byp_fetch_ready", 32'(bus.pix_ready), 32'd1);
        chk("byp_busy", 32'(bus.busy), 32'd1);
        step();
        chk("byp_emit1_valid", 32'(bus.out_valid), 32'd1);
        chk_out("byp_px1", 8'd10, 8'd20, 8'd30);
        set_pix(8'd40, 8'd50, 8'd60);
        step();
        chk("byp_fetch2_ready", 32'(bus.pix_ready), 32'd1);
        chk("byp_fetch2_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk_out("byp_px2", 8'd40, 8'd50, 8'd60);
        set_pix(8'd70, 8'd80, 8'd90);
        step();
        step();
        chk_out("byp_px3", 8'd70, 8'd80, 8'd90);
        chk("byp_no_early_done", 32'(fd_cnt), 32'd0);
        step();
        chk("byp_frame_done", 32'(bus.frame_done), 32'd1);
`ifdef COMP_CTRL_STATS_EN
        chk("byp_pix_count", 32'(pix_count), 32'd3);
`endif
        step();
        chk("byp_done_low", 32'(bus.frame_done), 32'd0);
        chk("byp_idle", 32'(bus.busy), 32'd0);
        chk("byp_no_start", 32'(sc_cnt), 32'd0);
        chk("byp_done_count", 32'(fd_cnt), 32'd1);

        // ---- invert, done 3 cycles after start, 5 cycles backpressure ----
        sc_cnt = 0;
        bus.num_pixels  = 16'd1;
        bus.mode_in     = 2'b01;
        bus.out_ready   = 1'b0;
        set_pix(8'h12, 8'h34, 8'h56);
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        step();
        chk("inv_start", 32'(bus.start_comp), 32'd1);
        chk("inv_comp_r", 32'(bus.comp_r), 32'h12);
        chk("inv_comp_b", 32'(bus.comp_b), 32'h56);
        chk("inv_comp_mode", 32'(bus.comp_mode), 32'd1);
        bus.res_r = 8'hED;
        bus.res_g = 8'hCB;
        bus.res_b = 8'hA9;
        step();
        chk("inv_start_low", 32'(bus.start_comp), 32'd0);
        step();
        step();
        bus.comp_done = 1'b1;
        chk("inv_wait_valid", 32'(bus.out_valid), 32'd0);
        chk("inv_hold_comp_g", 32'(bus.comp_g), 32'h34);
        step();
        chk("inv_emit_valid", 32'(bus.out_valid), 32'd1);
        chk_out("inv_out", 8'hED, 8'hCB, 8'hA9);
        chk("inv_timeout_err", 32'(bus.timeout_err), 32'd0);
        chk("inv_one_start", 32'(sc_cnt), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_pix_ready", 32'(bus.pix_ready), 32'd0);
            chk_out("bp_out", 8'hED, 8'hCB, 8'hA9);
        end
        bus.out_ready = 1'b1;
        step();
        chk("inv_frame_done", 32'(bus.frame_done), 32'd1);
        bus.comp_done = 1'b0;
        step();
        chk("inv_idle", 32'(bus.busy), 32'd0);

        // ---- watchdog timeout ----
        bus.num_pixels  = 16'd1;
        bus.mode_in     = 2'b10;
        set_pix(8'd1, 8'd2, 8'd3);
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        step();
        chk("to_launch", 32'(bus.start_comp), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("to_wait_valid", 32'(bus.out_valid), 32'd0);
        end
        step();
        chk("to_emit_valid", 32'(bus.out_valid), 32'd1);
        chk_out("to_out", 8'd1, 8'd2, 8'd3);
        chk("to_err_set", 32'(bus.timeout_err), 32'd1);
`ifdef COMP_CTRL_STATS_EN
        chk("to_count1", 32'(to_count), 32'd1);
`endif
        step();
        step();
        chk("to_err_sticky", 32'(bus.timeout_err), 32'd1);

        // ---- comp_done stuck high, 2 pixels ----
        fd_cnt = 0;
        bus.comp_done   = 1'b1;
        bus.num_pixels  = 16'd2;
        bus.mode_in     = 2'b11;
        set_pix(8'd4, 8'd5, 8'd6);
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        chk("stk_err_cleared", 32'(bus.timeout_err), 32'd0);
        step();
        for (int i = 0; i < 8; i++) step();
        step();
        chk("stk_emit1_valid", 32'(bus.out_valid), 32'd1);
        chk_out("stk_px1", 8'd4, 8'd5, 8'd6);
        chk("stk_err1", 32'(bus.timeout_err), 32'd1);
        set_pix(8'd7, 8'd8, 8'd9);
        step();
        chk("stk_fetch2", 32'(bus.pix_ready), 32'd1);
        step();
        for (int i = 0; i < 8; i++) step();
        step();
        chk("stk_emit2_valid", 32'(bus.out_valid), 32'd1);
        chk_out("stk_px2", 8'd7, 8'd8, 8'd9);
`ifdef COMP_CTRL_STATS_EN
        chk("stk_to_count", 32'(to_count), 32'd3);
`endif
        step();
        chk("stk_frame_done", 32'(bus.frame_done), 32'd1);
        step();
        chk("stk_done_count", 32'(fd_cnt), 32'd1);
        bus.comp_done = 1'b0;

        // ---- empty frame ----
        fd_cnt = 0;
        bus.num_pixels  = 16'd0;
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        chk("emp_frame_done", 32'(bus.frame_done), 32'd1);
        chk("emp_busy", 32'(bus.busy), 32'd1);
        step();
        chk("emp_busy_low", 32'(bus.busy), 32'd0);
        chk("emp_done_count", 32'(fd_cnt), 32'd1);

        // ---- reset in WAIT ----
        bus.num_pixels  = 16'd1;
        bus.mode_in     = 2'b01;
        set_pix(8'hAA, 8'hBB, 8'hCC);
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        step();
        step();
        step();
        chk("rw_in_wait", 32'(bus.busy), 32'd1);
        fd_cnt = 0;
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        chk("rw_busy", 32'(bus.busy), 32'd0);
        chk("rw_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rw_start", 32'(bus.start_comp), 32'd0);
        chk("rw_comp_r", 32'(bus.comp_r), 32'd0);
        chk("rw_comp_mode", 32'(bus.comp_mode), 32'd0);
        chk_out("rw_out", 8'h00, 8'h00, 8'h00);
`ifdef COMP_CTRL_STATS_EN
        chk("rw_to_count", 32'(to_count), 32'd0);
`endif
        step();
        chk("rw_no_frame_done", 32'(fd_cnt), 32'd0);
        set_pix(8'h11, 8'h22, 8'h33);
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        step();
        chk("rw_relaunch", 32'(bus.start_comp), 32'd1);
        step();
        bus.comp_done = 1'b1;
        bus.res_r = 8'hEE;
        bus.res_g = 8'hDD;
        bus.res_b = 8'hCC;
        step();
        chk("rw_emit_valid", 32'(bus.out_valid), 32'd1);
        chk_out("rw_res", 8'hEE, 8'hDD, 8'hCC);
        step();
        chk("rw_frame_done", 32'(bus.frame_done), 32'd1);
        bus.comp_done = 1'b0;
        step();
        chk("rw_idle", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
